shift_register_sequencer: RTL and testbench

- Controller that sequences the N-bit parallel-load universal shift register: load a word, shift it K times left or right with a chosen fill bit, stream out the bits that leave, capture the final word.
- Drives the register's SEL, DATA_IN, Ileft and Iright pins and reads back its OUT bus.
- Register SEL encoding: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
- Sits between a requesting client (START/DONE handshake) and the register instance.

---
 rtl/shift_register_sequencer.sv | 129 ++++++++++++
 tb/tb_shift_register_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Sequencer for an N-bit parallel-load universal shift register: loads a word,
// shifts it K times with a fill bit, streams the departing bits, captures the result.
module shift_register_sequencer #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          DIR,
    input  logic          FILL,
    input  logic [N-1:0]  DATA_IN,
    input  logic [CW-1:0] COUNT,
    input  logic [N-1:0]  REG_Q,
    output logic [1:0]    SEL,
    output logic [N-1:0]  REG_D,
    output logic          ILEFT,
    output logic          IRIGHT,
    output logic          SER_OUT,
    output logic          SER_VALID,
    output logic          BUSY,
    output logic          DONE,
    output logic [N-1:0]  RESULT
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    localparam logic [CW-1:0] N_SAT = CW'(N);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] shift_cnt;
    logic [CW-1:0] shift_cnt_next;
    logic [CW-1:0] k_sat;
    logic          dir_q;
    logic          fill_q;
    logic          accept;
    logic [1:0]    sel_next;
    logic          fill_next;

    assign k_sat  = (COUNT > N_SAT) ? N_SAT : COUNT;
    assign accept = (state == IDLE) && START;

    // Outputs are decoded from the next state so they appear registered in the cycle that state is entered
    always_comb begin
        state_next     = state;
        shift_cnt_next = shift_cnt;
        sel_next       = 2'b00;
        fill_next      = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    state_next     = LOAD;
                    shift_cnt_next = k_sat;
                end
            end
            LOAD: begin
                state_next = (shift_cnt != '0) ? SHIFT : FINISH;
            end
            SHIFT: begin
                shift_cnt_next = shift_cnt - CW'(1);
                if (shift_cnt == CW'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            LOAD:    sel_next = 2'b01;
            SHIFT: begin
                sel_next  = dir_q ? 2'b11 : 2'b10;
                fill_next = fill_q;
            end
            default: sel_next = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_cnt <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            SEL       <= 2'b00;
            REG_D     <= '0;
            ILEFT     <= 1'b0;
            IRIGHT    <= 1'b0;
            SER_OUT   <= 1'b0;
            SER_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RESULT    <= '0;
        end else begin
            state     <= state_next;
            shift_cnt <= shift_cnt_next;
            if (accept) begin
                dir_q  <= DIR;
                fill_q <= FILL;
                REG_D  <= DATA_IN;
            end
            SEL       <= sel_next;
            ILEFT     <= fill_next;
            IRIGHT    <= fill_next;
            BUSY      <= (state_next != IDLE);
            SER_VALID <= (state == SHIFT);
            // REG_Q still shows the pre-shift word here, so its edge bit is the one leaving
            if (state == SHIFT) begin
                SER_OUT <= dir_q ? REG_Q[0] : REG_Q[N-1];
            end
            DONE <= (state == FINISH);
            if (state == FINISH) begin
                RESULT <= REG_Q;
            end
        end
    end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: a universal shift register stand-in, an
// operation-level timing model checked every cycle, and directed literal checks.
module tb_shift_register_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       DIR = 1'b0;
    logic       FILL = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic [3:0] COUNT = 4'h0;
    logic [7:0] REG_Q;
    logic [1:0] SEL;
    logic [7:0] REG_D;
    logic       ILEFT;
    logic       IRIGHT;
    logic       SER_OUT;
    logic       SER_VALID;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    int checks = 0;
    int errors = 0;

    shift_register_sequencer #(.N(8), .CW(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .DIR      (DIR),
        .FILL     (FILL),
        .DATA_IN  (DATA_IN),
        .COUNT    (COUNT),
        .REG_Q    (REG_Q),
        .SEL      (SEL),
        .REG_D    (REG_D),
        .ILEFT    (ILEFT),
        .IRIGHT   (IRIGHT),
        .SER_OUT  (SER_OUT),
        .SER_VALID(SER_VALID),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    always #5 CLK = ~CLK;

    // Universal shift register driven by the sequencer
    logic [7:0] reg_q = 8'h00;
    assign REG_Q = reg_q;
    always @(posedge CLK) begin
        case (SEL)
            2'b01:   reg_q <= REG_D;
            2'b10:   reg_q <= {reg_q[6:0], ILEFT};
            2'b11:   reg_q <= {IRIGHT, reg_q[7:1]};
            default: reg_q <= reg_q;
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operation-level model: every output is a function of the cycle offset from the accepted START
    int         cyc = 0;
    logic       model_ready = 1'b0;
    logic       act = 1'b0;
    int         t0 = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_dir = 1'b0;
    logic       m_fill = 1'b0;
    int         m_k = 0;
    logic [1:0] exp_sel = 2'b00;
    logic [7:0] exp_reg_d = 8'h00;
    logic       exp_il = 1'b0;
    logic       exp_ser_out = 1'b0;
    logic       exp_ser_valid = 1'b0;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;
    logic [7:0] exp_result = 8'h00;

    always @(posedge CLK) begin
        int d;
        logic a;
        int t;
        logic [7:0] w;
        logic dr;
        logic fl;
        int k;
        logic [1:0] s;
        logic il;
        logic sv;
        logic b;
        logic dn;
        logic [7:0] body;
        logic [7:0] mask;
        a = act; t = t0; w = m_word; dr = m_dir; fl = m_fill; k = m_k;
        s = 2'b00; il = 1'b0; sv = 1'b0; b = 1'b0; dn = 1'b0;
        cyc <= cyc + 1;
        if (RST) begin
            model_ready   <= 1'b1;
            act           <= 1'b0;
            exp_sel       <= 2'b00;
            exp_reg_d     <= 8'h00;
            exp_il        <= 1'b0;
            exp_ser_out   <= 1'b0;
            exp_ser_valid <= 1'b0;
            exp_busy      <= 1'b0;
            exp_done      <= 1'b0;
            exp_result    <= 8'h00;
        end else begin
            if (START && !exp_busy) begin
                a = 1'b1; t = cyc; w = DATA_IN; dr = DIR; fl = FILL;
                k = (COUNT > 4'd8) ? 8 : int'(COUNT);
                exp_reg_d <= DATA_IN;
            end
            d = cyc + 1 - t;
            if (a) begin
                b = (d >= 1) && (d <= k + 2);
                if (d == 1) s = 2'b01;
                else if (d >= 2 && d <= k + 1) begin
                    s  = dr ? 2'b11 : 2'b10;
                    il = fl;
                end
                if (d >= 3 && d <= k + 2) begin
                    sv = 1'b1;
                    exp_ser_out <= dr ? w[d-3] : w[7-(d-3)];
                end
                if (d == k + 3) begin
                    dn = 1'b1;
                    if (dr) begin
                        body = w >> k;
                        mask = ~(8'hFF >> k);
                    end else begin
                        body = w << k;
                        mask = ~(8'hFF << k);
                    end
                    exp_result <= body | (fl ? mask : 8'h00);
                    a = 1'b0;
                end
            end
            act <= a; t0 <= t; m_word <= w; m_dir <= dr; m_fill <= fl; m_k <= k;
            exp_sel <= s; exp_il <= il; exp_ser_valid <= sv; exp_busy <= b; exp_done <= dn;
        end
    end

    always @(negedge CLK) begin
        if (model_ready) begin
            check_output("sel", SEL, exp_sel);
            check_output("reg_d", REG_D, exp_reg_d);
            check_output("ileft", ILEFT, exp_il);
            check_output("iright", IRIGHT, exp_il);
            check_output("ser_out", SER_OUT, exp_ser_out);
            check_output("ser_valid", SER_VALID, exp_ser_valid);
            check_output("busy", BUSY, exp_busy);
            check_output("done", DONE, exp_done);
            check_output("result", RESULT, exp_result);
        end
    end

    task automatic apply_stimulus(input logic [7:0] word, input logic dir, input logic fill, input logic [3:0] count);
        DATA_IN = word;
        DIR     = dir;
        FILL    = fill;
        COUNT   = count;
        START   = 1'b1;
    endtask

    // Called at the negedge of the START cycle; returns at the negedge of the DONE cycle
    task automatic wait_done(input string name, input int exp_lat, input logic [7:0] exp_res,
                             input logic [15:0] exp_ser, input int exp_nser,
                             input logic chk_frz, input logic [7:0] frz);
        int lat = 0;
        int nser = 0;
        logic [15:0] ser = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (i == 1) begin
                check_output({name, " load sel"}, SEL, 2'b01);
                if (chk_frz) check_output({name, " frozen reg"}, reg_q, frz);
            end
            if (SER_VALID) begin
                ser = {ser[14:0], SER_OUT};
                nser++;
            end
            if (DONE) begin
                lat = i;
                break;
            end
        end
        check_output({name, " done latency"}, lat, exp_lat);
        check_output({name, " result"}, RESULT, exp_res);
        check_output({name, " ser bits"}, ser, exp_ser);
        check_output({name, " ser count"}, nser, exp_nser);
    endtask

    initial begin
        logic [7:0] frz;
        // Reset held with START asserted
        START = 1'b1;
        DATA_IN = 8'hA5;
        COUNT = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_output("rst sel", SEL, 2'b00);
            check_output("rst busy", BUSY, 1'b0);
            check_output("rst done", DONE, 1'b0);
            check_output("rst result", RESULT, 8'h00);
            check_output("rst ser_valid", SER_VALID, 1'b0);
        end
        RST = 1'b0;
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_output("idle busy", BUSY, 1'b0);
            check_output("idle sel", SEL, 2'b00);
        end

        $display("[TB] left shift A5 by 3");
        apply_stimulus(8'hA5, 1'b0, 1'b0, 4'd3);
        wait_done("t2", 6, 8'h28, 16'h0005, 3, 1'b0, 8'h00);
        @(negedge CLK);

        $display("[TB] right shift 0F by 4 fill 1");
        apply_stimulus(8'h0F, 1'b1, 1'b1, 4'd4);
        wait_done("t3", 7, 8'hF0, 16'h000F, 4, 1'b0, 8'h00);
        @(negedge CLK);

        $display("[TB] zero count");
        apply_stimulus(8'h3C, 1'b0, 1'b1, 4'd0);
        wait_done("t4", 3, 8'h3C, 16'h0000, 0, 1'b0, 8'h00);
        @(negedge CLK);

        $display("[TB] saturated count then back-to-back");
        apply_stimulus(8'hFF, 1'b0, 1'b0, 4'd15);
        wait_done("t5a", 11, 8'h00, 16'h00FF, 8, 1'b0, 8'h00);
        apply_stimulus(8'h96, 1'b1, 1'b0, 4'd2);
        wait_done("t5b", 5, 8'h25, 16'h0001, 2, 1'b0, 8'h00);
        @(negedge CLK);

        $display("[TB] ignored START and mid-shift reset");
        apply_stimulus(8'h81, 1'b0, 1'b1, 4'd6);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        apply_stimulus(8'h55, 1'b1, 1'b0, 4'd1);
        @(negedge CLK);
        START = 1'b0;
        check_output("t6 busy kept", BUSY, 1'b1);
        check_output("t6 sel kept", SEL, 2'b10);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_output("t6 rst sel", SEL, 2'b00);
        check_output("t6 rst busy", BUSY, 1'b0);
        check_output("t6 rst done", DONE, 1'b0);
        check_output("t6 rst result", RESULT, 8'h00);
        check_output("t6 rst reg", reg_q, 8'h07);
        frz = reg_q;
        apply_stimulus(8'hC3, 1'b1, 1'b0, 4'd1);
        wait_done("t6", 4, 8'h61, 16'h0001, 1, 1'b1, frz);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
